// File: rtl/bsg_fifo_tracker_multi_add.sv
// Pointer/occupancy tracker for a circular buffer that can enqueue and dequeue
// up to max_add_p entries per cycle; both sides are judged against start-of-cycle state.
module bsg_fifo_tracker_multi_add #(
    parameter int slots_p   = 32,
    parameter int max_add_p = 5,
    localparam int ptr_width_lp = $clog2(slots_p),
    localparam int cnt_width_lp = $clog2(max_add_p + 1),
    localparam int occ_width_lp = $clog2(slots_p + 1)
) (
    input  logic                    clk,
    input  logic                    reset_i,

    input  logic                    enq_v_i,
    input  logic [cnt_width_lp-1:0] enq_cnt_i,
    output logic                    enq_ready_o,

    input  logic                    deq_v_i,
    input  logic [cnt_width_lp-1:0] deq_cnt_i,
    output logic                    deq_ready_o,

    output logic [ptr_width_lp-1:0] wptr_r_o,
    output logic [ptr_width_lp-1:0] rptr_r_o,
    output logic [cnt_width_lp-1:0] wadd_o,
    output logic [cnt_width_lp-1:0] radd_o,

    output logic [occ_width_lp-1:0] occ_r_o,
    output logic [occ_width_lp-1:0] free_r_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [1:0]              err_r_o
);

    localparam logic [ptr_width_lp:0]   slots_ptr_lp = (ptr_width_lp+1)'(slots_p);
    localparam logic [occ_width_lp-1:0] slots_occ_lp = occ_width_lp'(slots_p);
    localparam logic [31:0]             max_add_lp   = 32'(max_add_p);

    logic [ptr_width_lp-1:0] wptr_q, wptr_d;
    logic [ptr_width_lp-1:0] rptr_q, rptr_d;
    logic [occ_width_lp-1:0] occ_q,  occ_d;
    logic [1:0]              err_q,  err_d;

    logic                    enq_acc, deq_acc;
    // One extra bit so the wrap test is exact when slots_p is not a power of two
    logic [ptr_width_lp:0]   wsum, rsum;

    always_comb begin
        free_r_o = slots_occ_lp - occ_q;
        full_o   = (occ_q == slots_occ_lp);
        empty_o  = (occ_q == '0);
    end

    always_comb begin
        enq_ready_o = (32'(enq_cnt_i) <= max_add_lp) && (32'(enq_cnt_i) <= 32'(free_r_o));
        deq_ready_o = (32'(deq_cnt_i) <= max_add_lp) && (32'(deq_cnt_i) <= 32'(occ_q));
        enq_acc     = enq_v_i & enq_ready_o;
        deq_acc     = deq_v_i & deq_ready_o;
        wadd_o      = enq_acc ? enq_cnt_i : '0;
        radd_o      = deq_acc ? deq_cnt_i : '0;
    end

    always_comb begin
        wsum   = {1'b0, wptr_q} + (ptr_width_lp+1)'(wadd_o);
        rsum   = {1'b0, rptr_q} + (ptr_width_lp+1)'(radd_o);
        wptr_d = (wsum >= slots_ptr_lp) ? ptr_width_lp'(wsum - slots_ptr_lp)
                                        : wsum[ptr_width_lp-1:0];
        rptr_d = (rsum >= slots_ptr_lp) ? ptr_width_lp'(rsum - slots_ptr_lp)
                                        : rsum[ptr_width_lp-1:0];
        // Acceptance bounds keep this within 0..slots_p
        occ_d  = occ_width_lp'({1'b0, occ_q} + (occ_width_lp+1)'(wadd_o)
                                             - (occ_width_lp+1)'(radd_o));
        err_d  = err_q | {deq_v_i & ~deq_ready_o, enq_v_i & ~enq_ready_o};
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            err_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            err_q  <= err_d;
        end
    end

    assign wptr_r_o = wptr_q;
    assign rptr_r_o = rptr_q;
    assign occ_r_o  = occ_q;
    assign err_r_o  = err_q;

endmodule

// File: tb/tb_bsg_fifo_tracker_multi_add.sv
// Directed vectors plus randomized traffic against a modulo-arithmetic model.
module tb_bsg_fifo_tracker_multi_add;
    localparam int SLOTS = 32;
    localparam int MAXA  = 5;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       enq_v_i, deq_v_i;
    logic [2:0] enq_cnt_i, deq_cnt_i;
    logic       enq_ready_o, deq_ready_o;
    logic [4:0] wptr_r_o, rptr_r_o;
    logic [2:0] wadd_o, radd_o;
    logic [5:0] occ_r_o, free_r_o;
    logic       full_o, empty_o;
    logic [1:0] err_r_o;

    int n_vec = 0;
    int n_err = 0;

    bsg_fifo_tracker_multi_add #(.slots_p(SLOTS), .max_add_p(MAXA)) dut (
        .clk(clk), .reset_i(reset_i),
        .enq_v_i(enq_v_i), .enq_cnt_i(enq_cnt_i), .enq_ready_o(enq_ready_o),
        .deq_v_i(deq_v_i), .deq_cnt_i(deq_cnt_i), .deq_ready_o(deq_ready_o),
        .wptr_r_o(wptr_r_o), .rptr_r_o(rptr_r_o), .wadd_o(wadd_o), .radd_o(radd_o),
        .occ_r_o(occ_r_o), .free_r_o(free_r_o), .full_o(full_o), .empty_o(empty_o),
        .err_r_o(err_r_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic drv(input bit ev, input int ec, input bit dv, input int dc);
        enq_v_i = ev; enq_cnt_i = 3'(ec);
        deq_v_i = dv; deq_cnt_i = 3'(dc);
        #1;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic idle;
        drv(0, 0, 0, 0);
    endtask

    task automatic chk_state(input string tag, input int w, input int r, input int o, input int e);
        chk({tag, ".wptr"}, int'(wptr_r_o), w);
        chk({tag, ".rptr"}, int'(rptr_r_o), r);
        chk({tag, ".occ"},  int'(occ_r_o),  o);
        chk({tag, ".free"}, int'(free_r_o), SLOTS - o);
        chk({tag, ".full"}, int'(full_o),   int'(o == SLOTS));
        chk({tag, ".empty"},int'(empty_o),  int'(o == 0));
        chk({tag, ".err"},  int'(err_r_o),  e);
    endtask

    task automatic do_reset;
        reset_i = 1'b1; idle(); tick(); tick();
        reset_i = 1'b0;
    endtask

    int mw, mr, mo, me;

    initial begin
        reset_i = 1'b1;
        idle();
        @(negedge clk);
        do_reset();

        // reset and idle
        tick(); tick(); tick();
        chk_state("rst", 0, 0, 0, 0);

        // fill to full, wptr wraps 30 -> 0
        drv(1, 5, 0, 0);
        chk("fill.wadd", int'(wadd_o), 5);
        for (int i = 0; i < 6; i++) tick();
        chk_state("fill30", 30, 0, 30, 0);
        drv(1, 2, 0, 0);
        chk("fill2.wadd", int'(wadd_o), 2);
        tick();
        chk_state("full", 0, 0, 32, 0);

        // overflow attempt
        drv(1, 1, 0, 0);
        chk("ovf.rdy", int'(enq_ready_o), 0);
        chk("ovf.wadd", int'(wadd_o), 0);
        tick();
        chk_state("ovf", 0, 0, 32, 1);

        // full: same-cycle dequeue does not free space for enqueue
        drv(1, 3, 1, 3);
        chk("fd.enq_rdy", int'(enq_ready_o), 0);
        chk("fd.deq_rdy", int'(deq_ready_o), 1);
        chk("fd.wadd", int'(wadd_o), 0);
        chk("fd.radd", int'(radd_o), 3);
        tick();
        chk_state("fd", 0, 3, 29, 1);

        // bring both pointers to 29, then wrap them
        do_reset();
        for (int i = 0; i < 5; i++) begin drv(1, 5, 0, 0); tick(); end
        drv(1, 4, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin drv(0, 0, 1, 5); tick(); end
        drv(0, 0, 1, 4); tick();
        chk_state("at29", 29, 29, 0, 0);
        drv(1, 5, 0, 0);
        chk("wrapw.wadd", int'(wadd_o), 5);
        tick();
        chk_state("wrapw", 2, 29, 5, 0);
        drv(0, 0, 1, 5);
        chk("wrapr.radd", int'(radd_o), 5);
        tick();
        chk_state("wrapr", 2, 2, 0, 0);

        // underflow attempt with occ=2
        drv(1, 2, 0, 0); tick();
        drv(0, 0, 1, 3);
        chk("unf.rdy", int'(deq_ready_o), 0);
        chk("unf.radd", int'(radd_o), 0);
        tick();
        chk_state("unf", 4, 2, 2, 2);
        drv(0, 0, 1, 2);
        chk("deq2.radd", int'(radd_o), 2);
        tick();
        chk_state("deq2", 4, 4, 0, 2);

        // zero-count requests are accepted no-ops, even when empty
        drv(1, 0, 1, 0);
        chk("z.enq_rdy", int'(enq_ready_o), 1);
        chk("z.deq_rdy", int'(deq_ready_o), 1);
        tick();
        chk_state("zero", 4, 4, 0, 2);

        // count above max_add_p is rejected even with room
        drv(1, 6, 0, 0);
        chk("big.rdy", int'(enq_ready_o), 0);
        chk("big.wadd", int'(wadd_o), 0);
        tick();
        chk_state("big", 4, 4, 0, 3);

        // reset mid-traffic overrides an enqueue
        drv(1, 3, 0, 0); tick();
        reset_i = 1'b1; drv(1, 4, 0, 0); tick();
        reset_i = 1'b0; idle();
        chk_state("rstmid", 0, 0, 0, 0);

        // random traffic against a model
        mw = 0; mr = 0; mo = 0; me = 0;
        for (int c = 0; c < 10000; c++) begin
            bit ev, dv, er, dr;
            int ec, dc, wa, ra;
            ev = 1'($urandom_range(0, 1)); ec = int'($urandom_range(0, MAXA));
            dv = 1'($urandom_range(0, 1)); dc = int'($urandom_range(0, MAXA));
            drv(ev, ec, dv, dc);
            er = (ec <= SLOTS - mo);
            dr = (dc <= mo);
            wa = (ev && er) ? ec : 0;
            ra = (dv && dr) ? dc : 0;
            chk("rnd.wadd", int'(wadd_o), wa);
            chk("rnd.radd", int'(radd_o), ra);
            tick();
            mw = (mw + wa) % SLOTS;
            mr = (mr + ra) % SLOTS;
            mo = mo + wa - ra;
            if (ev && !er) me = me | 1;
            if (dv && !dr) me = me | 2;
            chk("rnd.wptr", int'(wptr_r_o), mw);
            chk("rnd.rptr", int'(rptr_r_o), mr);
            chk("rnd.occ",  int'(occ_r_o),  mo);
            chk("rnd.err",  int'(err_r_o),  me);
            chk("rnd.inv", (int'(wptr_r_o) - int'(rptr_r_o) + SLOTS) % SLOTS, int'(occ_r_o) % SLOTS);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
